// File: rtl/lsu_data_port.sv
// lsu_data_port
// Initiator side of the CPU data-memory req/gnt/rvalid interface. Accepts one
// load/store from execute, rejects misaligned accesses, drives the memory
// request with a size/offset byte-enable code and replicated store data, waits
// for grant and read data, then returns the extended load result to writeback.
// At most one transaction is outstanding.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   lsu_valid_i .. lsu_rd_i    access from execute
//   lsu_ready_o                high while IDLE (access can be accepted)
//   wb_valid_o/wb_rd_o/wb_data_o  registered load result (1-cycle pulse)
//   store_done_o               1-cycle pulse when a store is granted
//   misalign_o                 1-cycle pulse when an access is rejected
//   bus_err_o                  1-cycle pulse on timeout abort
//   data_*_o, rd_in_data_o     memory request side
//   data_gnt_i, data_rvalid_i, data_rdata_i, rd_out_data_i  memory response side
module lsu_data_port #(
  parameter int TIMEOUT   = 255,
  parameter int ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_unsigned_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  lsu_rd_i,
  output logic        lsu_ready_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        store_done_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        data_req_o,
  output logic [31:0] data_add_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  output logic [4:0]  rd_in_data_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic [4:0]  rd_out_data_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RV = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Access attributes held for the load extraction.
  logic [1:0]       size_p0;
  logic             uns_p0;
  logic [1:0]       off_p0;
  logic [4:0]       rd_p0;

  // The memory echoes the rd tag, but the LSU relies on its own latched copy.
  logic             unused_rd_tag;
  assign unused_rd_tag = ^rd_out_data_i;

  assign lsu_ready_o = (state == S_IDLE);

  // Counter wraps harmlessly when TIMEOUT is 0; the compare is disabled then.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] be_code(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] r;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   r = 4'b1000;
          2'b01:   r = 4'b1001;
          2'b10:   r = 4'b1010;
          default: r = 4'b1100;
        endcase
      end
      2'b01:   r = {3'b001, off[1]};
      default: r = 4'b0001;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rep_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mask_addr(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = (i < ADDR_BITS) ? a[i] : 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = uns ? 32'($unsigned(b)) : 32'(b);
      2'b01:   r = uns ? 32'($unsigned(h)) : 32'(h);
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Stage p0: access attributes captured at accept (data only, no reset).
  always_ff @(posedge clk) begin
    if (lsu_valid_i && lsu_ready_o) begin
      size_p0 <= lsu_size_i;
      uns_p0  <= lsu_unsigned_i;
      off_p0  <= lsu_addr_i[1:0];
      rd_p0   <= lsu_rd_i;
    end
  end

  // Control FSM with registered bus and writeback outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      tmo_cnt      <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      store_done_o <= 1'b0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
      data_req_o   <= 1'b0;
      data_add_o   <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
      rd_in_data_o <= '0;
    end else begin
      wb_valid_o   <= 1'b0;
      store_done_o <= 1'b0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lsu_valid_i) begin
            if (is_misaligned(lsu_size_i, lsu_addr_i[1:0])) begin
              misalign_o <= 1'b1;
            end else begin
              state        <= S_REQ;
              tmo_cnt      <= '0;
              data_req_o   <= 1'b1;
              data_add_o   <= mask_addr(lsu_addr_i);
              data_we_o    <= lsu_we_i;
              data_be_o    <= be_code(lsu_size_i, lsu_addr_i[1:0]);
              data_wdata_o <= rep_wdata(lsu_size_i, lsu_wdata_i);
              rd_in_data_o <= lsu_rd_i;
            end
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            if (data_we_o) begin
              store_done_o <= 1'b1;
              state        <= S_IDLE;
            end else if (data_rvalid_i) begin
              wb_valid_o <= 1'b1;
              wb_rd_o    <= rd_p0;
              wb_data_o  <= extract_load(data_rdata_i, size_p0, uns_p0, off_p0);
              state      <= S_IDLE;
            end else begin
              tmo_cnt <= '0;
              state   <= S_WAIT_RV;
            end
          end else if (tmo_hit) begin
            data_req_o <= 1'b0;
            bus_err_o  <= 1'b1;
            state      <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WAIT_RV: begin
          if (data_rvalid_i) begin
            wb_valid_o <= 1'b1;
            wb_rd_o    <= rd_p0;
            wb_data_o  <= extract_load(data_rdata_i, size_p0, uns_p0, off_p0);
            state      <= S_IDLE;
          end else if (tmo_hit) begin
            bus_err_o <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_data_port.sv
// tb_lsu_data_port
// Directed and randomized transactions against lsu_data_port (TIMEOUT=8,
// ADDR_BITS=16), with expected values from a transaction-level model.
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid_i, lsu_we_i, lsu_unsigned_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [4:0]  lsu_rd_i;
  logic        lsu_ready_o, wb_valid_o, store_done_o, misalign_o, bus_err_o;
  logic [4:0]  wb_rd_o, rd_in_data_o, rd_out_data_i;
  logic [31:0] wb_data_o, data_add_o, data_wdata_o, data_rdata_i;
  logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
  logic [3:0]  data_be_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_data_port #(.TIMEOUT(8), .ADDR_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid_i(lsu_valid_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_rd_i(lsu_rd_i), .lsu_ready_o(lsu_ready_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .store_done_o(store_done_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .data_req_o(data_req_o), .data_add_o(data_add_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .rd_in_data_o(rd_in_data_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .rd_out_data_i(rd_out_data_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] a);
    if (size >= 2) return (a % 4) != 0;
    if (size == 1) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
    int o = int'(a % 4);
    if (size >= 2) return 4'b0001;
    if (size == 1) return (o < 2) ? 4'b0010 : 4'b0011;
    case (o)
      0: return 4'b1000;
      1: return 4'b1001;
      2: return 4'b1010;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 0) return (w & 32'hFF) * 32'h01010101;
    if (size == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input bit uns,
                                         input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * (a % 4));
    if (size == 0) begin
      v = v & 32'hFF;
      if (!uns && v >= 128) v = v | 32'hFFFFFF00;
    end else if (size == 1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32768) v = v | 32'hFFFF0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, lsu_ready_o, 1);
    chk({tag, "_wbv"}, wb_valid_o, 0);
    chk({tag, "_wbrd"}, wb_rd_o, 0);
    chk({tag, "_wbdata"}, wb_data_o, 0);
    chk({tag, "_sdone"}, store_done_o, 0);
    chk({tag, "_mis"}, misalign_o, 0);
    chk({tag, "_berr"}, bus_err_o, 0);
    chk({tag, "_req"}, data_req_o, 0);
    chk({tag, "_add"}, data_add_o, 0);
    chk({tag, "_we"}, data_we_o, 0);
    chk({tag, "_be"}, data_be_o, 0);
    chk({tag, "_wdata"}, data_wdata_o, 0);
    chk({tag, "_rdin"}, rd_in_data_o, 0);
  endtask

  // One complete access: gdly cycles without grant, then rdly cycles from
  // grant to read data (0 = rvalid together with gnt).
  task automatic xact(input string tag, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                      input int gdly, input int rdly, input logic [31:0] rdata);
    chk({tag, "_ready"}, lsu_ready_o, 1);
    lsu_valid_i = 1; lsu_we_i = we; lsu_size_i = size; lsu_unsigned_i = uns;
    lsu_addr_i = addr; lsu_wdata_i = wd; lsu_rd_i = rd;
    step();
    lsu_valid_i = 0;
    lsu_addr_i = $urandom; lsu_wdata_i = $urandom; lsu_rd_i = 5'($urandom);
    lsu_size_i = 2'($urandom); lsu_we_i = 1'($urandom); lsu_unsigned_i = 1'($urandom);
    if (m_misaligned(size, addr)) begin
      chk({tag, "_mis"}, misalign_o, 1);
      chk({tag, "_misreq"}, data_req_o, 0);
      step();
      chk({tag, "_mis2"}, misalign_o, 0);
      chk({tag, "_misreq2"}, data_req_o, 0);
      chk({tag, "_misrdy"}, lsu_ready_o, 1);
      return;
    end
    chk({tag, "_nomis"}, misalign_o, 0);
    for (int k = 0; k <= gdly; k++) begin
      chk({tag, "_req"}, data_req_o, 1);
      chk({tag, "_add"}, data_add_o, addr % 65536);
      chk({tag, "_we"}, data_we_o, we);
      chk({tag, "_be"}, data_be_o, m_be(size, addr));
      chk({tag, "_wdata"}, data_wdata_o, m_wdata(size, wd));
      chk({tag, "_rdin"}, rd_in_data_o, rd);
      chk({tag, "_busy"}, lsu_ready_o, 0);
      if (k < gdly) begin
        data_rvalid_i = 1'($urandom);
        data_rdata_i = $urandom;
        step();
        chk({tag, "_nowb"}, wb_valid_o, 0);
      end
    end
    data_gnt_i = 1;
    data_rvalid_i = (!we && rdly == 0);
    data_rdata_i = rdata;
    step();
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = $urandom;
    chk({tag, "_reqdrop"}, data_req_o, 0);
    if (we) begin
      chk({tag, "_sdone"}, store_done_o, 1);
      chk({tag, "_swb"}, wb_valid_o, 0);
      step();
      chk({tag, "_sdone2"}, store_done_o, 0);
      chk({tag, "_srdy"}, lsu_ready_o, 1);
      return;
    end
    chk({tag, "_lsdone"}, store_done_o, 0);
    if (rdly > 0) begin
      chk({tag, "_wait"}, wb_valid_o, 0);
      chk({tag, "_waitrdy"}, lsu_ready_o, 0);
      for (int k = 1; k < rdly; k++) begin
        step();
        chk({tag, "_wait"}, wb_valid_o, 0);
      end
      data_rvalid_i = 1; data_rdata_i = rdata;
      step();
      data_rvalid_i = 0; data_rdata_i = $urandom;
    end
    chk({tag, "_wbv"}, wb_valid_o, 1);
    chk({tag, "_wbdata"}, wb_data_o, m_load(size, uns, addr, rdata));
    chk({tag, "_wbrd"}, wb_rd_o, rd);
    chk({tag, "_rdy"}, lsu_ready_o, 1);
    step();
    chk({tag, "_wbv2"}, wb_valid_o, 0);
  endtask

  initial begin
    rst_n = 0;
    lsu_valid_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_unsigned_i = 0;
    lsu_addr_i = 0; lsu_wdata_i = 0; lsu_rd_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0; rd_out_data_i = 5'd3;
    step();
    step();
    chk_reset_outputs("reset");
    rst_n = 1;
    step();

    // Directed cases
    xact("lw_0x10", 0, 2'b10, 0, 32'h10, 0, 5'd7, 0, 0, 32'hDEADBEEF);
    xact("lb_0x13", 0, 2'b00, 0, 32'h13, 0, 5'd9, 0, 0, 32'h80112233);
    xact("lbu_0x13", 0, 2'b00, 1, 32'h13, 0, 5'd9, 0, 0, 32'h80112233);
    xact("sh_0x22", 1, 2'b01, 0, 32'h22, 32'h1234ABCD, 5'd1, 3, 0, 0);
    xact("lw_0x06", 0, 2'b10, 0, 32'h06, 0, 5'd2, 0, 0, 32'h0);
    xact("lh_wait", 0, 2'b01, 0, 32'h0001_0016, 0, 5'd31, 1, 2, 32'h9ABC_1234);
    xact("sb_hi", 1, 2'b00, 0, 32'hFFFF_FFFF, 32'h0000_00A5, 5'd4, 0, 0, 0);

    // Timeout: no grant ever
    lsu_valid_i = 1; lsu_we_i = 0; lsu_size_i = 2'b10; lsu_addr_i = 32'h40; lsu_rd_i = 5'd5;
    step();
    lsu_valid_i = 0;
    chk("tmo_req", data_req_o, 1);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("tmo_reqheld", data_req_o, 1);
      chk("tmo_noerr", bus_err_o, 0);
    end
    step();
    chk("tmo_berr", bus_err_o, 1);
    chk("tmo_reqdrop", data_req_o, 0);
    chk("tmo_nowb", wb_valid_o, 0);
    step();
    chk("tmo_berr2", bus_err_o, 0);
    chk("tmo_rdy", lsu_ready_o, 1);

    // Reset in the middle of REQ
    lsu_valid_i = 1; lsu_we_i = 0; lsu_size_i = 2'b10; lsu_addr_i = 32'h44; lsu_rd_i = 5'd6;
    step();
    lsu_valid_i = 0;
    step();
    step();
    chk("rstmid_req", data_req_o, 1);
    rst_n = 0;
    step();
    chk_reset_outputs("rstmid");
    rst_n = 1;
    step();
    chk_reset_outputs("rstmid_after");

    // Randomized accesses
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom);
      a = $urandom;
      if ($urandom_range(9) < 7) begin
        if (sz >= 2) a = a & ~32'h3;
        else if (sz == 1) a = a & ~32'h1;
      end
      xact("rand", 1'($urandom), sz, 1'($urandom), a, $urandom, 5'($urandom),
           int'($urandom_range(4)), int'($urandom_range(4)), $urandom);
      if ($urandom_range(3) == 0) begin
        step();
        chk("rand_idle", lsu_ready_o, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
